// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT front-end.
// Sizes match the FFT_Fixed core configuration.
package fft_pkg;

    localparam int WIDTH_IN = 9;
    localparam int ARRAY_IN = 16;
    localparam int N_POINT  = 512;
    localparam int BEATS    = N_POINT / ARRAY_IN;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } fft_seq_state_t;

    typedef logic signed [WIDTH_IN-1:0] sample_t;

endpackage

// File: rtl/fft_frame_sequencer.sv
// Feeds one frame from the sample buffer into FFT_Fixed
// and tracks its output beats to completion or timeout.
module fft_frame_sequencer #(
    parameter int WIDTH_IN = fft_pkg::WIDTH_IN,
    parameter int ARRAY_IN = fft_pkg::ARRAY_IN,
    parameter int N_POINT  = fft_pkg::N_POINT,
    parameter int ADDR_W   = 5,
    parameter int TIMEOUT  = 1023
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    input  logic [ARRAY_IN*WIDTH_IN-1:0] mem_rd_i,
    input  logic [ARRAY_IN*WIDTH_IN-1:0] mem_rd_q,
    output logic                         din_valid,
    output logic [ARRAY_IN*WIDTH_IN-1:0] din_i,
    output logic [ARRAY_IN*WIDTH_IN-1:0] din_q,
    input  logic                         do_en,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_timeout,
    output logic                         err_spurious,
    output logic [15:0]                  frame_cnt
);

    localparam int BEATS = N_POINT / ARRAY_IN;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    fft_pkg::fft_seq_state_t state, state_nxt;

    logic          rd_dly;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] to_cnt;
    logic          last_rd;
    logic          feed_end;
    logic          drain_done;
    logic          drain_to;

    assign last_rd    = mem_rd_en && (mem_rd_addr == ADDR_W'(BEATS - 1));
    // din_valid trails rd_dly by one cycle, so this marks the final beat
    assign feed_end   = din_valid && !rd_dly;
    assign drain_done = (beat_cnt == BW'(BEATS))
                     || (do_en && beat_cnt == BW'(BEATS - 1));
    assign drain_to   = !do_en && (to_cnt == TW'(TIMEOUT - 1));

    assign busy       = (state != fft_pkg::IDLE);
    assign frame_done = (state == fft_pkg::DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            fft_pkg::IDLE:  if (start) state_nxt = fft_pkg::FEED;
            fft_pkg::FEED:  if (feed_end) state_nxt = fft_pkg::DRAIN;
            fft_pkg::DRAIN: begin
                if (drain_done)    state_nxt = fft_pkg::DONE;
                else if (drain_to) state_nxt = fft_pkg::IDLE;
            end
            fft_pkg::DONE:  state_nxt = fft_pkg::IDLE;
            default:        state_nxt = fft_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= fft_pkg::IDLE;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == fft_pkg::IDLE && start) begin
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= '0;
            end else if (mem_rd_en) begin
                mem_rd_en   <= !last_rd;
                mem_rd_addr <= mem_rd_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_dly    <= 1'b0;
            din_valid <= 1'b0;
            din_i     <= '0;
            din_q     <= '0;
        end else begin
            rd_dly    <= mem_rd_en;
            din_valid <= rd_dly;
            if (rd_dly) begin
                din_i <= mem_rd_i;
                din_q <= mem_rd_q;
            end
        end
    end

    // Output beats arriving while still feeding are part of the frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (state == fft_pkg::IDLE)
                beat_cnt <= '0;
            else if (do_en && beat_cnt != BW'(BEATS))
                beat_cnt <= beat_cnt + 1'b1;
            if (state == fft_pkg::DRAIN && !do_en)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            err_timeout  <= (state == fft_pkg::DRAIN) && !drain_done && drain_to;
            err_spurious <= (state == fft_pkg::IDLE) && do_en;
            if (state == fft_pkg::DONE)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a ramp
// frame buffer and a stub FFT output strobe.
module tb_fft_frame_sequencer;
    import fft_pkg::*;

    localparam int W = ARRAY_IN * WIDTH_IN;

    logic         clk;
    logic         rstn;
    logic         start;
    logic         mem_rd_en;
    logic [4:0]   mem_rd_addr;
    logic [W-1:0] mem_rd_i;
    logic [W-1:0] mem_rd_q;
    logic         din_valid;
    logic [W-1:0] din_i;
    logic [W-1:0] din_q;
    logic         do_en;
    logic         busy;
    logic         frame_done;
    logic         err_timeout;
    logic         err_spurious;
    logic [15:0]  frame_cnt;

    fft_frame_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_i(mem_rd_i), .mem_rd_q(mem_rd_q),
        .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
        .do_en(do_en), .busy(busy), .frame_done(frame_done),
        .err_timeout(err_timeout), .err_spurious(err_spurious),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] exp_frames = 16'd0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // lane k of beat b holds 16b+k; imag lanes hold 511 minus that
    function automatic logic [W-1:0] ramp(input int b, input bit q);
        logic [W-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < ARRAY_IN; k++) begin
            v = ARRAY_IN * b + k;
            if (q) v = N_POINT - 1 - v;
            r[k*WIDTH_IN +: WIDTH_IN] = v[WIDTH_IN-1:0];
        end
        return r;
    endfunction

    initial begin
        mem_rd_i = '0;
        mem_rd_q = '0;
    end
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_i <= ramp(int'(mem_rd_addr), 1'b0);
            mem_rd_q <= ramp(int'(mem_rd_addr), 1'b1);
        end
    end

    int stub_delay = 40;
    int stub_n = 32;
    bit spur_req = 1'b0;
    bit seen = 1'b0;
    int k_cyc = 0;
    initial do_en = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (!busy) seen = 1'b0;
        if (!seen && din_valid) begin
            seen = 1'b1;
            k_cyc = 0;
        end else if (seen) begin
            k_cyc++;
        end
        do_en = spur_req || (seen && k_cyc >= stub_delay
                             && k_cyc < stub_delay + stub_n);
    end

    typedef struct {
        string name;
        int    delay;
        int    n_do;
        bit    spam;
        bit    exp_done;
        bit    exp_to;
    } vec_t;

    vec_t vecs[4];

    task automatic run_frame(input vec_t v);
        int  first_dv, dv_cnt, dv_runs, rd_cnt, rd_bad, lane_bad;
        int  done_cnt, done_n, to_cnt, to_n, spur_cnt, last_do, fin_n;
        bit  prev_dv, finished;
        first_dv = -1; dv_cnt = 0; dv_runs = 0; rd_cnt = 0; rd_bad = 0;
        lane_bad = 0; done_cnt = 0; done_n = -1; to_cnt = 0; to_n = -1;
        spur_cnt = 0; last_do = -1; fin_n = -1;
        prev_dv = 1'b0; finished = 1'b0;
        stub_delay = v.delay;
        stub_n = v.n_do;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 1600; n++) begin
            @(negedge clk);
            if (n == 1)
                check({v.name, "_rd_first"},
                      {58'd0, mem_rd_en, mem_rd_addr}, {58'd0, 1'b1, 5'd0});
            if (mem_rd_en) begin
                if (mem_rd_addr != rd_cnt[4:0]) rd_bad++;
                rd_cnt++;
            end
            if (din_valid) begin
                if (dv_cnt == 0) first_dv = n;
                if (!prev_dv) dv_runs++;
                if (din_i !== ramp(dv_cnt, 1'b0)
                    || din_q !== ramp(dv_cnt, 1'b1)) lane_bad++;
                dv_cnt++;
            end
            prev_dv = din_valid;
            if (do_en) last_do = n;
            if (frame_done) begin
                done_cnt++;
                done_n = n;
            end
            if (err_timeout) begin
                to_cnt++;
                to_n = n;
            end
            if (err_spurious) spur_cnt++;
            if (!finished && (frame_done || err_timeout)) begin
                finished = 1'b1;
                fin_n = n;
            end
            start = v.spam && !finished;
            if (finished && n >= fin_n + 4) break;
        end
        start = 1'b0;
        check({v.name, "_ended"}, 64'(finished), 64'd1);
        check({v.name, "_rd_cnt"}, 64'(rd_cnt), 64'd32);
        check({v.name, "_rd_addr_seq"}, 64'(rd_bad), 64'd0);
        check({v.name, "_dv_first"}, 64'(first_dv), 64'd3);
        check({v.name, "_dv_cnt"}, 64'(dv_cnt), 64'd32);
        check({v.name, "_dv_runs"}, 64'(dv_runs), 64'd1);
        check({v.name, "_lanes"}, 64'(lane_bad), 64'd0);
        check({v.name, "_done_cnt"}, 64'(done_cnt), 64'(v.exp_done));
        check({v.name, "_to_cnt"}, 64'(to_cnt), 64'(v.exp_to));
        if (v.exp_done)
            check({v.name, "_done_at"}, 64'(done_n), 64'(last_do + 1));
        if (v.exp_to)
            check({v.name, "_to_at"}, 64'(to_n), 64'(last_do + 1024));
        if (v.exp_done) exp_frames = exp_frames + 16'd1;
        check({v.name, "_busy_end"}, 64'(busy), 64'd0);
        check({v.name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
        check({v.name, "_spurious"}, 64'(spur_cnt), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dvc;
        int sp_cnt;
        int sp_at;
        vecs[0] = '{"norm",  40, 32, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"spam",  40, 32, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{"short", 40, 31, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{"early",  5, 32, 1'b0, 1'b1, 1'b0};

        rstn = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            spur_req = 1'($urandom);
            @(negedge clk);
            check("rst_ctl", {57'd0, mem_rd_en, mem_rd_addr, din_valid,
                  busy, frame_done, err_timeout, err_spurious}, 64'd0);
            check("rst_din", 64'((|din_i) | (|din_q)), 64'd0);
            check("rst_cnt", 64'(frame_cnt), 64'd0);
        end
        start = 1'b0;
        spur_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        stub_delay = 40;
        stub_n = 32;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dvc = 0;
        for (int n = 2; n < 100 && dvc < 10; n++) begin
            if (din_valid) dvc++;
            @(negedge clk);
        end
        check("abort_pre_dv", 64'(din_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("abort_dv", 64'(din_valid), 64'd0);
        check("abort_ctl", {61'd0, busy, mem_rd_en, err_timeout}, 64'd0);
        check("abort_cnt", 64'(frame_cnt), 64'd0);
        exp_frames = 16'd0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(vecs[0]);

        @(negedge clk);
        spur_req = 1'b1;
        @(negedge clk);
        spur_req = 1'b0;
        sp_cnt = 0;
        sp_at = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (err_spurious) begin
                sp_cnt++;
                sp_at = i;
            end
        end
        check("spur_cnt", 64'(sp_cnt), 64'd1);
        check("spur_at", 64'(sp_at), 64'd1);
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_frames", 64'(frame_cnt), 64'(exp_frames));

        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        exp_frames = 16'hFFFF;
        run_frame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
